data_memory: RTL

Word-addressed data memory for the RV32IM pipelined CPU, sitting directly downstream of the CPU's memory-access stage. It consumes `MEM_READ`, `MEM_WRITE`, `MEM_ADDRESS` and `MEM_WRITE_DATA` from the CPU and returns `READ_DATA` and `BUSYWAIT`. It models a fixed multi-cycle access latency. While an access is outstanding, `BUSYWAIT` stalls the pipeline; it drops for exactly one cycle when the access completes, so the CPU advances once.

---
 rtl/data_memory.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Word-addressed data memory behind the CPU memory-access stage. Every access
//   takes a fixed number of clock edges. BUSYWAIT stalls the pipeline while an
//   access is outstanding, then drops for exactly one cycle (DONE) so the CPU
//   advances once.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//   LATENCY     : rising edges from request capture to completion (>= 1)
//
// Ports
//   CLK            in   1  rising-edge clock
//   RESET          in   1  asynchronous, active-high reset
//   MEM_READ       in   1  load request, held until BUSYWAIT is seen low
//   MEM_WRITE      in   1  store request, held until BUSYWAIT is seen low
//   MEM_ADDRESS    in  32  byte address; word index = [log2(DEPTH)+1:2]
//   MEM_WRITE_DATA in  32  store data
//   READ_DATA      out 32  registered load result
//   BUSYWAIT       out  1  stall request to the CPU
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q,    wr_d;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   rdata_q;

    // Access strobe and operands for the edge that performs the access.
    logic          acc_en;
    logic          acc_wr;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_data;

    logic          req;
    logic [AW-1:0] req_idx;

    assign req     = MEM_READ | MEM_WRITE;
    // Upper bits wrap the array; low two bits select a byte we never use.
    assign req_idx = MEM_ADDRESS[AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{MEM_ADDRESS[31:AW+2], MEM_ADDRESS[1:0]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic, including the captured request copy and counter.
    // The counter holds the number of edges still to go after the capture
    // edge; the access fires on the BUSY edge where it reads 1.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = MEM_WRITE_DATA;
                    // Read+write together is treated as a write.
                    wr_d    = MEM_WRITE;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Inputs still show the completed access here; ignore them.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: BUSYWAIT and the access strobe.
    // -------------------------------------------------------------------------
    always_comb begin
        BUSYWAIT = 1'b0;
        acc_en   = 1'b0;
        acc_wr   = wr_q;
        acc_idx  = idx_q;
        acc_data = wdata_q;
        case (state_q)
            S_IDLE: begin
                // Combinational so the stall is seen in the request's own cycle.
                BUSYWAIT = req;
                // Single-edge latency: the capture edge is also the access edge,
                // so the operands come straight from the inputs.
                if (LATENCY == 1 && req) begin
                    acc_en   = 1'b1;
                    acc_wr   = MEM_WRITE;
                    acc_idx  = req_idx;
                    acc_data = MEM_WRITE_DATA;
                end
            end
            S_BUSY: begin
                BUSYWAIT = 1'b1;
                if (cnt_q == CW'(1)) begin
                    acc_en = 1'b1;
                end
            end
            S_DONE: begin
                BUSYWAIT = 1'b0;
            end
            default: begin
                BUSYWAIT = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Captured request and latency counter
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array and read register. Reset clears every word, so a reset in
    // the middle of a write leaves the array all-zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else if (acc_en) begin
            if (acc_wr) begin
                mem_q[acc_idx] <= acc_data;
            end else begin
                rdata_q <= mem_q[acc_idx];
            end
        end
    end

    assign READ_DATA = rdata_q;

endmodule
